// File: rtl/keypad_encoder_pkg.sv
// Shared keypad definitions: FSM states, sample classes, idle pattern, code width.
// Imported by keypad_encoder and by the watch-side consumer.
package keypad_encoder_pkg;

  localparam int N_KEYS        = 10;
  localparam int CODE_W        = 4;
  localparam int DEBOUNCE_CYC  = 20;
  localparam int REPEAT_DELAY  = 500;
  localparam int REPEAT_PERIOD = 200;

  localparam logic [N_KEYS-1:0] KEY_NONE = '1;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } cls_t;

  typedef struct packed {
    cls_t              cls;
    logic [CODE_W-1:0] idx;
  } sample_t;

  // idx is only meaningful when cls == CLS_SINGLE
  function automatic sample_t classify(input logic [N_KEYS-1:0] s);
    sample_t r;
    int      n;
    r.idx = '0;
    n     = 0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!s[i]) begin
        n++;
        r.idx = CODE_W'(i);
      end
    end
    unique case (1'b1)
      (n == 0): r.cls = CLS_NONE;
      (n == 1): r.cls = CLS_SINGLE;
      default:  r.cls = CLS_MULTI;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_encoder_sync.sv
// Two-flop synchroniser for the raw keypad pins, reset to the idle pattern.
module key_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Keypad front end: sync, classify, debounce, single press events.
// Build with KEYPAD_REPEAT_EN defined to add hold-to-repeat pulses.
module keypad_encoder
  import keypad_encoder_pkg::*;
#(
  parameter int DB_CYC     = DEBOUNCE_CYC,
  parameter int REP_DELAY  = REPEAT_DELAY,
  parameter int REP_PERIOD = REPEAT_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keypad,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held,
  output logic              key_multi
);

  localparam int CNT_W = $clog2(DB_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYC - 1);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REP_DELAY);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RLD = REP_W'(REP_DELAY - REP_PERIOD);
  logic [REP_W-1:0] rep;
`endif

  logic [N_KEYS-1:0] sync_q;
  sample_t           smp;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] cand;
  logic              is_none;
  logic              is_cand;

  key_sync #(.W(N_KEYS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (keypad),
    .q   (sync_q)
  );

  assign smp     = classify(sync_q);
  assign is_none = (smp.cls == CLS_NONE);
  assign is_cand = (smp.cls == CLS_SINGLE) && (smp.idx == cand);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
      key_multi <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep       <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      key_multi <= (smp.cls == CLS_MULTI);
      unique case (state)
        IDLE: begin
          if (smp.cls == CLS_SINGLE) begin
            state <= DEBOUNCE;
            cand  <= smp.idx;
            cnt   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!is_cand) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state     <= PRESSED;
            key_valid <= 1'b1;
            key_code  <= cand;
            key_held  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (is_none) begin
            state <= RELEASE;
            cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep   <= '0;
          end else if (rep == REP_MAX) begin
            key_valid <= 1'b1;
            rep       <= REP_RLD;
          end else begin
            rep <= rep + 1'b1;
`endif
          end
        end
        RELEASE: begin
          if (!is_none) begin
            state <= PRESSED;
          end else if (cnt == CNT_MAX) begin
            state    <= IDLE;
            key_held <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Self-checking bench for keypad_encoder: directed table plus random
// stimulus against a run-length reference model.
module tb_keypad_encoder;

  localparam int DB = 20;
  localparam int RD = 500;
  localparam int RP = 200;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_ON = 1'b1;
  localparam int HOLD_PULSES = 4;
`else
  localparam bit REP_ON = 1'b0;
  localparam int HOLD_PULSES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] keypad = '1;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic       key_multi;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  keypad_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .keypad    (keypad),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .key_multi (key_multi)
  );

  // reference model state
  logic [9:0] q1, q2;
  bit         armed;
  int         streak, quiet, hold_t, cand;
  logic [3:0] m_code;
  bit         m_valid, m_held, m_multi;

  function automatic logic [9:0] kp(input int k);
    logic [9:0] one;
    one = 10'd1;
    return ~(one << k);
  endfunction

  task automatic model_reset();
    q1 = '1; q2 = '1;
    armed = 1; streak = 0; quiet = 0; hold_t = 0; cand = 0;
    m_code = 0; m_valid = 0; m_held = 0; m_multi = 0;
  endtask

  // one clock edge: the FSM sees the sample two edges behind the pins
  task automatic model_edge();
    logic [9:0] s;
    int n, k;
    s = q2; q2 = q1; q1 = keypad;
    n = 0; k = 0;
    for (int i = 0; i < 10; i++)
      if (!s[i]) begin n++; k = i; end
    m_valid = 0;
    m_multi = (n > 1);
    if (armed) begin
      if (streak == 0) begin
        if (n == 1) begin streak = 1; cand = k; end
      end else if (n == 1 && k == cand) begin
        streak++;
        if (streak == DB + 1) begin
          m_valid = 1; m_code = 4'(cand); m_held = 1;
          armed = 0; quiet = 0; hold_t = 0; streak = 0;
        end
      end else begin
        streak = 0;
      end
    end else if (n == 0) begin
      quiet++;
      hold_t = 0;
      if (quiet == DB + 1) begin armed = 1; m_held = 0; streak = 0; end
    end else begin
      if (quiet == 0) begin
        hold_t++;
        if (REP_ON && hold_t >= RD && (hold_t - RD) % RP == 0) m_valid = 1;
      end
      quiet = 0;
    end
  endtask

  task automatic compare(input string name);
    vectors++;
    if ({key_valid, key_code, key_held, key_multi} !==
        {m_valid, m_code, m_held, m_multi}) begin
      miscompares++;
      $display("FAIL %s t=%0t got v=%b c=%0d h=%b m=%b want v=%b c=%0d h=%b m=%b",
               name, $time, key_valid, key_code, key_held, key_multi,
               m_valid, m_code, m_held, m_multi);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    compare(name);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  typedef struct {
    logic [9:0] keys;
    int         cycles;
    int         pulses;
    int         first;
    int         code;
    int         fall;
  } step_t;

  task automatic run_step(input step_t st, input string name);
    int pulses, first, code, fall;
    bit prev_held;
    pulses = 0; first = 0; code = -1; fall = 0;
    keypad = st.keys;
    prev_held = key_held;
    for (int c = 1; c <= st.cycles; c++) begin
      tick(name);
      if (key_valid) begin
        pulses++;
        if (first == 0) first = c;
        code = int'(key_code);
      end
      if (prev_held && !key_held && fall == 0) fall = c;
      prev_held = key_held;
    end
    check_int({name, "_pulses"}, pulses, st.pulses);
    if (st.first != 0) check_int({name, "_first"}, first, st.first);
    if (st.pulses != 0) check_int({name, "_code"}, code, st.code);
    if (st.fall != 0) check_int({name, "_fall"}, fall, st.fall);
  endtask

  step_t steps[$];
  step_t hold_steps[$];

  initial begin
    model_reset();
    // key 7 clean press and release
    steps.push_back('{kp(7), 40, 1, 23, 7, 0});
    steps.push_back('{'1, 30, 0, 0, 0, 23});
    // key 3 bouncing then stable
    for (int b = 0; b < 3; b++) begin
      steps.push_back('{kp(3), 5, 0, 0, 0, 0});
      steps.push_back('{'1, 5, 0, 0, 0, 0});
    end
    steps.push_back('{kp(3), 40, 1, 23, 3, 0});
    steps.push_back('{'1, 30, 0, 0, 0, 23});
    // chord 1+4, then 4 released
    steps.push_back('{kp(1) & kp(4), 50, 0, 0, 0, 0});
    steps.push_back('{kp(1), 40, 1, 23, 1, 0});
    steps.push_back('{'1, 30, 0, 0, 0, 23});
    // second key while holding
    steps.push_back('{kp(5), 40, 1, 23, 5, 0});
    steps.push_back('{kp(5) & kp(2), 20, 0, 0, 0, 0});
    steps.push_back('{kp(5), 20, 0, 0, 0, 0});
    steps.push_back('{'1, 30, 0, 0, 0, 23});
    steps.push_back('{kp(2), 40, 1, 23, 2, 0});
    steps.push_back('{'1, 30, 0, 0, 0, 23});
    // long hold of key 0
    hold_steps.push_back('{kp(0), 1000, HOLD_PULSES, 23, 0, 0});
    hold_steps.push_back('{'1, 30, 0, 0, 0, 23});

    repeat (3) tick("reset_state");
    #2 rst = 1'b1;

    foreach (steps[i]) run_step(steps[i], $sformatf("step%0d", i));

    // reset while debouncing key 9
    run_step('{kp(9), 13, 0, 0, 0, 0}, "rst_pre");
    #2 rst = 1'b0;
    #1 model_reset();
    compare("rst_async");
    repeat (3) tick("rst_hold");
    #2 rst = 1'b1;
    run_step('{kp(9), 40, 1, 23, 9, 0}, "rst_post");
    run_step('{'1, 30, 0, 0, 0, 23}, "rst_rel");

    foreach (hold_steps[i]) run_step(hold_steps[i], $sformatf("hold%0d", i));

    // random segments against the model
    for (int seg = 0; seg < 120; seg++) begin
      int kind, len, a, b;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 45);
      a    = $urandom_range(0, 9);
      b    = (a + $urandom_range(1, 9)) % 10;
      if (kind < 4) keypad = '1;
      else if (kind < 9) keypad = kp(a);
      else keypad = kp(a) & kp(b);
      repeat (len) tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
